// File: rtl/zed64_console_pkg.sv
// -----------------------------------------------------------------------------
// zed64_console_pkg
// Shared definitions for the console writer that fills the character-cell half
// of VRAM:
//   - control-code constants recognised in the input byte stream
//   - console FSM state encoding
//   - default geometry and blank fill code
//   - is_printable(): classifies a byte as a displayable character code
// No ports (package).
// -----------------------------------------------------------------------------
package zed64_console_pkg;

   localparam logic [7:0] CC_BS = 8'h08;
   localparam logic [7:0] CC_LF = 8'h0A;
   localparam logic [7:0] CC_FF = 8'h0C;
   localparam logic [7:0] CC_CR = 8'h0D;

   localparam int         DEF_COLS       = 80;
   localparam int         DEF_ROWS       = 48;
   localparam logic [7:0] DEF_BLANK_CHAR = 8'h20;

   typedef enum logic [1:0] {
      CLR_SCREEN = 2'd0,
      IDLE       = 2'd1,
      CLR_LINE   = 2'd2
   } console_state_t;

   // Codes 0x00..0x07 are glyphs in this character set, not controls.
   function automatic logic is_printable(input logic [7:0] c);
      return (c >= 8'h20) || (c <= 8'h07);
   endfunction

endpackage

// File: rtl/console_clear_seq.sv
// -----------------------------------------------------------------------------
// console_clear_seq
// Emits a run of consecutive cell addresses, one per clock, used to blank a
// single row or the whole screen.
//   pixel_clock, reset_n : clock, asynchronous active-low reset
//   start                : load base/count and begin the run
//   base                 : first address of the run
//   count                : number of cells to write (ADDR_W+1 bits so a full
//                          2**ADDR_W screen is representable)
//   adr, wr              : current address and its write strobe
//   done                 : one-clock pulse on the clock after the last strobe
// -----------------------------------------------------------------------------
module console_clear_seq #(
   parameter int ADDR_W = 12
) (
   input  logic              pixel_clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] adr,
   output logic              wr,
   output logic              done
);

   logic              active_r;
   logic [ADDR_W-1:0] adr_r;
   logic [ADDR_W:0]   left_r;
   logic              done_r;

   localparam logic [ADDR_W:0]   LEFT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   // Run counter: walk the address upward until the remaining count is spent.
   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         active_r <= 1'b0;
         adr_r    <= '0;
         left_r   <= '0;
         done_r   <= 1'b0;
      end else if (start) begin
         active_r <= 1'b1;
         adr_r    <= base;
         left_r   <= count;
         done_r   <= 1'b0;
      end else if (active_r) begin
         adr_r    <= adr_r + ADR_ONE;
         left_r   <= left_r - LEFT_ONE;
         active_r <= (left_r != LEFT_ONE);
         done_r   <= (left_r == LEFT_ONE);
      end else begin
         done_r   <= 1'b0;
      end
   end

   assign adr  = adr_r;
   assign wr   = active_r;
   assign done = done_r;

endmodule

// File: rtl/vram_console_writer.sv
// -----------------------------------------------------------------------------
// vram_console_writer
// Interprets a host byte stream and writes character codes into the cell region
// of VRAM. The screen is a ring of rows; top_row names the ring row shown on the
// first display line so scrolling needs no copy.
//   pixel_clock, reset_n        : clock, asynchronous active-low reset
//   in_char, in_valid, in_ready : byte input handshake
//   vram_wr_en/adr/dat          : cell RAM write port (adr = row*COLS + col)
//   cursor_col, cursor_row      : cursor position (ring row)
//   top_row                     : ring row displayed first
//   busy_clear                  : a row or screen blank is running
//   cursor_blink                : blink phase
// Optional feature macro: CONSOLE_CURSOR_BLINK_EN (free-running blink counter,
// cleared on every accepted byte). Without it cursor_blink is constant 1.
// -----------------------------------------------------------------------------
module vram_console_writer
   import zed64_console_pkg::*;
#(
   parameter int         COLS       = DEF_COLS,
   parameter int         ROWS       = DEF_ROWS,
   parameter int         ADDR_W     = 12,
   parameter logic [7:0] BLANK_CHAR = DEF_BLANK_CHAR,
   parameter int         BLINK_LOG2 = 24
) (
   input  logic                    pixel_clock,
   input  logic                    reset_n,
   input  logic [7:0]              in_char,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    vram_wr_en,
   output logic [ADDR_W-1:0]       vram_wr_adr,
   output logic [7:0]              vram_wr_dat,
   output logic [$clog2(COLS)-1:0] cursor_col,
   output logic [$clog2(ROWS)-1:0] cursor_row,
   output logic [$clog2(ROWS)-1:0] top_row,
   output logic                    busy_clear,
   output logic                    cursor_blink
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);

   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
   localparam logic [ADDR_W-1:0] PITCH    = ADDR_W'(COLS);
   localparam logic [ADDR_W:0]   LINE_CNT = (ADDR_W+1)'(COLS);
   localparam logic [ADDR_W:0]   SCRN_CNT = (ADDR_W+1)'(COLS * ROWS);

   console_state_t    state_r;
   logic              start_r;
   logic              wrapped_r;
   logic [ADDR_W-1:0] row_base_r;   // cursor_row * COLS, kept incrementally

   logic              xfer_s;
   logic              advance_s;
   logic [ROW_W-1:0]  next_row_s;
   logic [ROW_W-1:0]  next_top_s;
   logic [ADDR_W-1:0] next_base_s;
   logic              next_wrapped_s;
   logic [ADDR_W-1:0] seq_base_s;
   logic [ADDR_W:0]   seq_count_s;
   logic [ADDR_W-1:0] seq_adr_s;
   logic              seq_wr_s;
   logic              seq_done_s;

   assign xfer_s = in_valid & in_ready;

   // Row-advance arithmetic: next ring row, its base address, and scroll origin.
   always_comb begin
      next_row_s     = '0;
      next_base_s    = '0;
      next_wrapped_s = wrapped_r;
      next_top_s     = top_row;
      if (cursor_row == LAST_ROW) begin
         next_row_s     = '0;
         next_base_s    = '0;
         next_wrapped_s = 1'b1;
      end else begin
         next_row_s     = cursor_row + ROW_ONE;
         next_base_s    = row_base_r + PITCH;
         next_wrapped_s = wrapped_r;
      end
      // Once the ring has wrapped, the row after the cursor is the oldest line.
      if (next_wrapped_s) begin
         if (next_row_s == LAST_ROW) begin
            next_top_s = '0;
         end else begin
            next_top_s = next_row_s + ROW_ONE;
         end
      end else begin
         next_top_s = top_row;
      end
   end

   // Decide whether the accepted byte moves the cursor to a new row.
   always_comb begin
      advance_s = 1'b0;
      if ((state_r == IDLE) && xfer_s) begin
         if (is_printable(in_char)) begin
            advance_s = (cursor_col == LAST_COL);
         end else begin
            advance_s = (in_char == CC_LF);
         end
      end else begin
         advance_s = 1'b0;
      end
   end

   // Clear-run geometry: whole screen from 0, or the freshly entered row.
   always_comb begin
      seq_base_s  = '0;
      seq_count_s = '0;
      if (state_r == CLR_SCREEN) begin
         seq_base_s  = '0;
         seq_count_s = SCRN_CNT;
      end else begin
         seq_base_s  = row_base_r;
         seq_count_s = LINE_CNT;
      end
   end

   console_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
      .pixel_clock (pixel_clock),
      .reset_n     (reset_n),
      .start       (start_r),
      .base        (seq_base_s),
      .count       (seq_count_s),
      .adr         (seq_adr_s),
      .wr          (seq_wr_s),
      .done        (seq_done_s)
   );

   // Console FSM with all outputs registered.
   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= CLR_SCREEN;
         start_r     <= 1'b1;   // kick the screen blank on the first clock after release
         wrapped_r   <= 1'b0;
         row_base_r  <= '0;
         in_ready    <= 1'b0;
         vram_wr_en  <= 1'b0;
         vram_wr_adr <= '0;
         vram_wr_dat <= 8'h00;
         cursor_col  <= '0;
         cursor_row  <= '0;
         top_row     <= '0;
         busy_clear  <= 1'b0;
      end else begin
         start_r    <= 1'b0;
         vram_wr_en <= 1'b0;
         case (state_r)
            CLR_SCREEN, CLR_LINE: begin
               busy_clear <= 1'b1;
               in_ready   <= 1'b0;
               if (seq_wr_s) begin
                  vram_wr_en  <= 1'b1;
                  vram_wr_adr <= seq_adr_s;
                  vram_wr_dat <= BLANK_CHAR;
               end
               if (seq_done_s) begin
                  busy_clear <= 1'b0;
                  in_ready   <= 1'b1;
                  state_r    <= IDLE;
                  if (state_r == CLR_SCREEN) begin
                     cursor_col <= '0;
                     cursor_row <= '0;
                     top_row    <= '0;
                     wrapped_r  <= 1'b0;
                     row_base_r <= '0;
                  end
               end
            end
            IDLE: begin
               busy_clear <= 1'b0;
               in_ready   <= 1'b1;
               if (xfer_s) begin
                  if (is_printable(in_char)) begin
                     vram_wr_en  <= 1'b1;
                     vram_wr_adr <= row_base_r + ADDR_W'(cursor_col);
                     vram_wr_dat <= in_char;
                     cursor_col  <= cursor_col + COL_ONE;
                  end else begin
                     case (in_char)
                        CC_CR: cursor_col <= '0;
                        CC_BS: begin
                           if (cursor_col != '0) begin
                              cursor_col <= cursor_col - COL_ONE;
                           end
                        end
                        CC_FF: begin
                           state_r    <= CLR_SCREEN;
                           start_r    <= 1'b1;
                           in_ready   <= 1'b0;
                           busy_clear <= 1'b1;
                        end
                        default: ;   // LF handled by advance_s; others consumed silently
                     endcase
                  end
                  if (advance_s) begin
                     cursor_col <= '0;
                     cursor_row <= next_row_s;
                     row_base_r <= next_base_s;
                     wrapped_r  <= next_wrapped_s;
                     top_row    <= next_top_s;
                     state_r    <= CLR_LINE;
                     start_r    <= 1'b1;
                     in_ready   <= 1'b0;
                     busy_clear <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= CLR_SCREEN;
               start_r <= 1'b1;
            end
         endcase
      end
   end

`ifdef CONSOLE_CURSOR_BLINK_EN
   logic [BLINK_LOG2:0] blink_cnt_r;

   // Free-running blink counter, held at zero while bytes arrive so the cursor stays solid.
   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt_r <= '0;
      end else if (xfer_s) begin
         blink_cnt_r <= '0;
      end else begin
         blink_cnt_r <= blink_cnt_r + {{BLINK_LOG2{1'b0}}, 1'b1};
      end
   end

   assign cursor_blink = blink_cnt_r[BLINK_LOG2];
`else
   // No counter: cursor permanently visible; the blink period is irrelevant here.
   assign cursor_blink = (BLINK_LOG2 >= 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_vram_console_writer.sv
// -----------------------------------------------------------------------------
// tb_vram_console_writer
// Directed stimulus against a screen-level model: every accepted byte is turned
// into the list of cell writes it must cause (in order, with the exact clock for
// character writes) plus the resulting cursor/top_row. A single compare process
// matches every DUT write against that list.
// -----------------------------------------------------------------------------
module tb_vram_console_writer;

   localparam int COLS  = 80;
   localparam int ROWS  = 48;
   localparam int CELLS = COLS * ROWS;

   logic        pixel_clock = 1'b0;
   logic        reset_n     = 1'b0;
   logic [7:0]  in_char     = 8'h00;
   logic        in_valid    = 1'b0;
   logic        in_ready;
   logic        vram_wr_en;
   logic [11:0] vram_wr_adr;
   logic [7:0]  vram_wr_dat;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic [5:0]  top_row;
   logic        busy_clear;
   logic        cursor_blink;

   vram_console_writer dut (
      .pixel_clock  (pixel_clock),
      .reset_n      (reset_n),
      .in_char      (in_char),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .vram_wr_en   (vram_wr_en),
      .vram_wr_adr  (vram_wr_adr),
      .vram_wr_dat  (vram_wr_dat),
      .cursor_col   (cursor_col),
      .cursor_row   (cursor_row),
      .top_row      (top_row),
      .busy_clear   (busy_clear),
      .cursor_blink (cursor_blink)
   );

   always #5 pixel_clock = ~pixel_clock;

   typedef struct {
      int adr;
      int dat;
      bit clear;
      int due;     // clock index at which a character write must appear; -1 = any
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  m_col, m_row, m_top;
   bit  m_wrapped;
   int  last_wr_cyc = 0, prev_wr_cyc = 0;
   int  n_clear_seen = 0;

   always @(posedge pixel_clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic void push_clear(input int base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back('{base + i, 32'h20, 1'b1, -1});
   endfunction

   function automatic void model_screen();
      m_col = 0; m_row = 0; m_top = 0; m_wrapped = 1'b0;
      push_clear(0, CELLS);
   endfunction

   function automatic void model_newline();
      m_col = 0;
      if (m_row == ROWS - 1) begin
         m_row = 0;
         m_wrapped = 1'b1;
      end else begin
         m_row++;
      end
      if (m_wrapped) m_top = (m_row + 1) % ROWS;
      push_clear(m_row * COLS, COLS);
   endfunction

   // Called just before the clock edge on which c is transferred.
   function automatic void model_accept(input logic [7:0] c);
      if (c >= 8'h20 || c <= 8'h07) begin
         exp_q.push_back('{m_row * COLS + m_col, int'(c), 1'b0, cyc + 1});
         if (m_col == COLS - 1) model_newline();
         else m_col++;
      end else if (c == 8'h0D) m_col = 0;
      else if (c == 8'h0A) model_newline();
      else if (c == 8'h08) begin
         if (m_col > 0) m_col--;
      end else if (c == 8'h0C) model_screen();
   endfunction

   // Compare every write the DUT makes against the model's ordered list.
   always @(negedge pixel_clock) begin
      if (reset_n) begin
         if (busy_clear) begin
            checks++;
            if (in_ready) begin
               errors++;
               $display("FAIL ready_in_busy: in_ready=1 while busy_clear=1 at cyc %0d", cyc);
            end
         end
         if (vram_wr_en) begin
            wr_t e;
            checks++;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: adr=%0d dat=%02h at cyc %0d, expected no write",
                        vram_wr_adr, vram_wr_dat, cyc);
            end else begin
               e = exp_q.pop_front();
               if (int'(vram_wr_adr) != e.adr || int'(vram_wr_dat) != e.dat ||
                   (e.clear && !busy_clear) || (e.due >= 0 && e.due != cyc)) begin
                  errors++;
                  $display("FAIL write: got adr=%0d dat=%02h busy=%0d cyc=%0d, expected adr=%0d dat=%02h clear=%0d due=%0d",
                           vram_wr_adr, vram_wr_dat, busy_clear, cyc, e.adr, e.dat, e.clear, e.due);
               end else if (e.clear) begin
                  n_clear_seen++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge pixel_clock);
      #1;
   endtask

   task automatic send(input logic [7:0] c);
      int n = 0;
      in_char  = c;
      in_valid = 1'b1;
      while (!in_ready && n < 6000) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         errors++;
         $display("FAIL send_timeout: byte %02h not accepted, in_ready=%0d, expected 1", c, in_ready);
      end else begin
         model_accept(c);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(in_ready && exp_q.size() == 0) && n < 6000) begin
         tick();
         n++;
      end
      chk({name, "_pending_writes"}, exp_q.size(), 0);
      chk({name, "_in_ready"}, int'(in_ready), 1);
      chk({name, "_col"}, int'(cursor_col), m_col);
      chk({name, "_row"}, int'(cursor_row), m_row);
      chk({name, "_top"}, int'(top_row), m_top);
   endtask

   task automatic chk_reset_values(input string name);
      chk({name, "_wr_en"}, int'(vram_wr_en), 0);
      chk({name, "_adr"}, int'(vram_wr_adr), 0);
      chk({name, "_dat"}, int'(vram_wr_dat), 0);
      chk({name, "_ready"}, int'(in_ready), 0);
      chk({name, "_busy"}, int'(busy_clear), 0);
      chk({name, "_col"}, int'(cursor_col), 0);
      chk({name, "_row"}, int'(cursor_row), 0);
      chk({name, "_top"}, int'(top_row), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      chk_reset_values("reset");
      reset_n = 1'b1;
      model_screen();
      wait_idle("boot");
      chk("boot_clear_count", n_clear_seen, 3840);
      chk("boot_col_lit", int'(cursor_col), 0);
      chk("boot_row_lit", int'(cursor_row), 0);
`ifndef CONSOLE_CURSOR_BLINK_EN
      chk("blink_tied", int'(cursor_blink), 1);
`endif

      // "AB": consecutive writes, cursor moves two columns, no stall.
      send(8'h41);
      send(8'h42);
      chk("ab_consecutive", last_wr_cyc - prev_wr_cyc, 1);
      chk("ab_col_lit", int'(cursor_col), 2);
      chk("ab_ready_lit", int'(in_ready), 1);
      send(8'h0D);
      wait_idle("cr_home");

      // 80 'X' fill row 0 then the next row is blanked.
      for (int i = 0; i < COLS; i++) send(8'h58);
      wait_idle("line_wrap");
      chk("wrap_row_lit", int'(cursor_row), 1);
      chk("wrap_col_lit", int'(cursor_col), 0);
      chk("wrap_top_lit", int'(top_row), 0);

      // Ignored controls consume nothing visible; 0x00 and 0xFF print.
      send(8'h09); send(8'h0B); send(8'h1F); send(8'h0E);
      send(8'h00); send(8'hFF); send(8'h07);
      wait_idle("codes");
      chk("codes_col_lit", int'(cursor_col), 3);

      send(8'h0C);
      wait_idle("ff1");

      // 48 line feeds wrap the ring; the 49th moves one further.
      for (int i = 0; i < ROWS; i++) send(8'h0A);
      wait_idle("lf48");
      chk("lf48_row_lit", int'(cursor_row), 0);
      chk("lf48_top_lit", int'(top_row), 1);
      send(8'h0A);
      wait_idle("lf49");
      chk("lf49_row_lit", int'(cursor_row), 1);
      chk("lf49_top_lit", int'(top_row), 2);

      send(8'h0C);
      wait_idle("ff2");
      send(8'h08);
      wait_idle("bs_col0");
      send(8'h51); send(8'h08); send(8'h52);
      wait_idle("q_bs_r");
      chk("q_bs_r_col_lit", int'(cursor_col), 1);
      send(8'h41); send(8'h42); send(8'h43); send(8'h44);
      chk("col5_lit", int'(cursor_col), 5);
      send(8'h0D);
      wait_idle("cr5");

      // FF mid-line with the next byte held valid across the whole clear.
      send(8'h5A); send(8'h5A);
      send(8'h0C);
      send(8'h4B);
      wait_idle("ff_held");
      chk("ff_held_col_lit", int'(cursor_col), 1);

      // Reset pulsed during a line clear restarts with a full screen clear.
      send(8'h0A);
      repeat (10) tick();
      reset_n = 1'b0;
      exp_q.delete();
      tick();
      chk_reset_values("midreset");
      reset_n = 1'b1;
      model_screen();
      wait_idle("after_reset");
      chk("after_reset_row_lit", int'(cursor_row), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
